kv32_mem_arbiter: RTL and testbench
===================================

# kv32_mem_arbiter

Shares one single-port, 1-cycle-read-latency unified memory between the kv32 core's instruction-fetch port and data port. Grants one requester per cycle. Data accesses take priority, and a starvation counter guarantees fetch progress. Routes each read response back to its originator with a valid pulse. Sits between `kv32_core` and a unified RAM with the same en/we/addr/din/dout interface as `dmem`. This block replaces the separate `imem`/`dmem` pair.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: byte-address width on all ports.
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is pending. Legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous, active-low.
- `i_req` input 1: fetch request. Held with `i_addr` stable until `i_gnt`.
- `i_addr` input ADDR_WIDTH: fetch address.
- `i_gnt` output 1: fetch accepted this cycle (combinational).
- `i_rvalid` output 1: fetch data valid on `i_rdata`.
- `i_rdata` output 32: fetch data.
- `d_req` input 1: data request. Held until `d_gnt`.
- `d_we` input 4: byte write enables. 0 means a read.
- `d_addr` input ADDR_WIDTH: data address.
- `d_wdata` input 32: write data.
- `d_gnt` output 1: data access accepted this cycle (combinational).
- `d_rvalid` output 1: read data valid on `d_rdata`. Reads only.
- `d_rdata` output 32: read data.
- `mem_en` output 1: memory enable.
- `mem_we` output 4: memory byte write enables.
- `mem_addr` output ADDR_WIDTH: memory address.
- `mem_din` output 32: memory write data.
- `mem_dout` input 32: memory read data, valid 1 cycle after an `mem_en` read.

## Operation

Arbitration is combinational each cycle:
- Only `d_req`: grant D.
- Only `i_req`: grant I.
- Both: grant D, unless `starve_cnt == STARVE_LIMIT`, in which case grant I.
- Neither: no grant; `mem_en=0`, `mem_we=0`.

Starvation counter `starve_cnt` (4 bits):
- Increments on a D grant while `i_req=1`.
- Clears on an I grant, or in any cycle with `i_req=0`.
- Saturates at `STARVE_LIMIT`.

Memory drive:
- On a grant, `mem_en=1`; `mem_addr` and `mem_din` come from the granted port.
- `mem_we` is `d_we` on a D grant and 0 on an I grant.
- With no grant, `mem_addr` and `mem_din` hold their last values. No memory activity occurs.

Response routing:
- A 2-bit registered response tag (NONE/I/D) is set on each read grant.
  - An I grant sets I.
  - A D grant with `d_we=0` sets D.
  - A write grant or no grant sets NONE.
- In the next cycle, the tag produces `i_rvalid` or `d_rvalid`.
- `i_rdata` and `d_rdata` are both wired to `mem_dout`. Each is meaningful only while its rvalid is high.

Requester rules:
- The requester must hold `req`, `addr`, `we` and `wdata` stable until `gnt`.
- Deasserting `req` before `gnt` is legal; the request is simply dropped.
- Back-to-back grants on consecutive cycles are legal. Full throughput is 1 access per cycle.

## Timing

- Grant latency: 0 cycles. `gnt` is asserted in the cycle the request wins.
- Read latency: `rvalid` is asserted exactly 1 cycle after `gnt`, for 1 cycle.
- Write completion: the write takes effect at the clock edge ending its grant cycle. A read of the same address granted in the next cycle returns the new data.
- Reset (`rst=0` sampled at a clock edge): `starve_cnt=0`, tag=NONE.
  - While `rst=0`: `i_gnt`, `d_gnt`, `mem_en`, `mem_we`, `i_rvalid` and `d_rvalid` are all 0.
  - `mem_addr` and `mem_din` are 0.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no rvalid. A pending request is not granted until the first cycle with `rst=1`.
- The grant path is combinational from `req` to `gnt` and `mem_*`. There is no combinational path from `mem_dout` to any `gnt`.

## Structure

- Shared package `kv32_pkg` holds:
  - `typedef enum logic [1:0] {SRC_NONE, SRC_I, SRC_D} kv32_mem_src_e`.
  - A `KV32_XLEN = 32` constant.
- Single module, no sub-modules. Comprises:
  - the arbitration mux,
  - the starvation counter,
  - the response-tag register,
  - a registered `mem_addr`/`mem_din` hold.
- Top-level `kv32` integration maps the core's `imem_*` and `dmem_*` ports onto `i_*` and `d_*` ports respectively.

## Test plan

- **Reset:** hold `rst=0` for 3 cycles with `i_req=d_req=1` → all gnt, rvalid, `mem_en` and `mem_we` are 0. At the first cycle with `rst=1`, `d_gnt=1`.
- **Write then read:** D write `d_we=4'hF`, `d_addr=0x100`, `d_wdata=0xDEADBEEF`; next cycle D read of 0x100 → `d_rvalid=1` one cycle later with `d_rdata=0xDEADBEEF`, and `i_rvalid` stays 0.
- **Byte write:** `d_we=4'b0010`, `d_wdata=0x0000AB00` onto a word holding 0x11223344 → a read returns 0x1122AB44.
- **Starvation:** with `STARVE_LIMIT=4`, hold `i_req` and `d_req` continuously → grant pattern D,D,D,D,I repeats. Each I grant is followed by `i_rvalid` carrying the fetch word for `i_addr`.
- **Contention routing:** alternate I read of 0x1000 and D read of 0x200 on consecutive cycles → each rvalid pulses only on its own port, carrying the correct word, at 1 access per cycle.
- **Reset mid-read:** grant an I read, then drive `rst=0` for the next cycle → `i_rvalid` stays 0 and `starve_cnt` returns to 0.

Source files
------------

// File: rtl/kv32_pkg.sv
// kv32 shared definitions.
// Common types and constants used across the kv32 core slice.
package kv32_pkg;

    localparam int KV32_XLEN = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_I,
        SRC_D
    } kv32_mem_src_e;

endpackage

// File: rtl/kv32_mem_arbiter.sv
// kv32 unified memory arbiter.
// Shares one 1-cycle-latency RAM between fetch and data ports.
module kv32_mem_arbiter
    import kv32_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [KV32_XLEN-1:0]  i_rdata,
    input  logic                  d_req,
    input  logic [3:0]            d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [KV32_XLEN-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [KV32_XLEN-1:0]  d_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [KV32_XLEN-1:0]  mem_din,
    input  logic [KV32_XLEN-1:0]  mem_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    kv32_mem_src_e         tag_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [KV32_XLEN-1:0]  din_q;
    logic                  starved;

    assign starved = i_req && (starve_cnt >= LIMIT);

    // Data wins unless fetch has been starved; nothing granted in reset.
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (rst) begin
            if (d_req && !starved) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Drive the RAM from the winner, else hold the last address/data.
    always_comb begin
        mem_en   = i_gnt | d_gnt;
        mem_we   = d_gnt ? d_we : 4'h0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (!rst) begin
            mem_addr = '0;
            mem_din  = '0;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end else if (i_gnt) begin
            mem_addr = i_addr;
        end
    end

    // Capture the granted address/data so idle cycles keep the bus quiet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (d_gnt) begin
            addr_q <= d_addr;
            din_q  <= d_wdata;
        end else if (i_gnt) begin
            addr_q <= i_addr;
        end
    end

    // Count data wins while a fetch waits; any fetch win or idle fetch clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt && starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Remember who owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q <= SRC_NONE;
        end else if (i_gnt) begin
            tag_q <= SRC_I;
        end else if (d_gnt && d_we == 4'h0) begin
            tag_q <= SRC_D;
        end else begin
            tag_q <= SRC_NONE;
        end
    end

    assign i_rvalid = rst && (tag_q == SRC_I);
    assign d_rvalid = rst && (tag_q == SRC_D);
    assign i_rdata  = mem_dout;
    assign d_rdata  = mem_dout;

endmodule

// File: tb/tb_kv32_mem_arbiter.sv
// Directed bench for kv32_mem_arbiter.
// Includes a behavioural unified RAM with 1-cycle read latency.
module tb_kv32_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:4095];

    int checks;
    int failures;

    localparam logic [31:0] FETCH_WORD = 32'hA5A5_0001;
    localparam logic [31:0] DATA_WORD  = 32'h0BAD_F00D;

    kv32_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unified RAM model: byte writes, registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) ram[mem_addr[13:2]][8*b +: 8] = mem_din[8*b +: 8];
                end
            end else begin
                mem_dout <= ram[mem_addr[13:2]];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        i_addr = 32'h1000;
        d_addr = 32'h200;
        d_we = 4'h0;
        d_wdata = 32'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            checks++;
            if ({i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid} !== 5'b0) begin
                failures++;
                $display("FAIL reset_ctl cyc=%0d got=%b want=00000", k,
                         {i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid});
            end
            checks++;
            if (mem_we !== 4'h0 || mem_addr !== 32'h0 || mem_din !== 32'h0) begin
                failures++;
                $display("FAIL reset_bus cyc=%0d we=%h addr=%h din=%h want 0",
                         k, mem_we, mem_addr, mem_din);
            end
        end
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL reset_release d_gnt=%b i_gnt=%b addr=%h want 1 0 200",
                     d_gnt, i_gnt, mem_addr);
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== DATA_WORD || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_read d_rvalid=%b d_rdata=%h i_rvalid=%b want 1 %h 0",
                     d_rvalid, d_rdata, i_rvalid, DATA_WORD);
        end
    endtask

    task automatic test_write_read;
        tick();
        d_req = 1'b1;
        d_we = 4'hF;
        d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 4'hF || mem_addr !== 32'h100
            || mem_din !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_drive gnt=%b we=%h addr=%h din=%h want 1 f 100 deadbeef",
                     d_gnt, mem_we, mem_addr, mem_din);
        end
        tick();
        d_we = 4'h0;
        #2;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 4'h0 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_drive gnt=%b we=%h rvalid=%b want 1 0 0",
                     d_gnt, mem_we, d_rvalid);
        end
        tick();
        d_req = 1'b0;
        d_addr = 32'h444;
        #2;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_data rvalid=%b data=%h i_rvalid=%b want 1 deadbeef 0",
                     d_rvalid, d_rdata, i_rvalid);
        end
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h100 || mem_din !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL idle_hold en=%b addr=%h din=%h want 0 100 deadbeef",
                     mem_en, mem_addr, mem_din);
        end
        tick();
        #2;
        checks++;
        if (d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_pulse d_rvalid=%b want 0", d_rvalid);
        end
    endtask

    task automatic test_byte_write;
        tick();
        d_req = 1'b1;
        d_we = 4'b0010;
        d_addr = 32'h300;
        d_wdata = 32'h0000_AB00;
        #2;
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 4'b0010) begin
            failures++;
            $display("FAIL byte_wr gnt=%b we=%b want 1 0010", d_gnt, mem_we);
        end
        tick();
        d_we = 4'h0;
        tick();
        d_req = 1'b0;
        #2;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122_AB44) begin
            failures++;
            $display("FAIL byte_rd rvalid=%b data=%h want 1 1122ab44",
                     d_rvalid, d_rdata);
        end
    endtask

    task automatic test_starvation;
        logic exp_i;
        logic prev_i;
        tick();
        i_req = 1'b1;
        i_addr = 32'h1000;
        d_req = 1'b1;
        d_addr = 32'h200;
        d_we = 4'h0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #2;
            exp_i = (c % 5 == 4);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                failures++;
                $display("FAIL starve_gnt cyc=%0d i=%b d=%b want i=%b d=%b",
                         c, i_gnt, d_gnt, exp_i, !exp_i);
            end
            if (c > 0) begin
                prev_i = ((c - 1) % 5 == 4);
                checks++;
                if (i_rvalid !== prev_i || d_rvalid !== !prev_i
                    || i_rdata !== (prev_i ? FETCH_WORD : DATA_WORD)) begin
                    failures++;
                    $display("FAIL starve_rsp cyc=%0d iv=%b dv=%b data=%h want iv=%b",
                             c, i_rvalid, d_rvalid, i_rdata, prev_i);
                end
            end
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        checks++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== FETCH_WORD) begin
            failures++;
            $display("FAIL starve_last iv=%b dv=%b data=%h want 1 0 %h",
                     i_rvalid, d_rvalid, i_rdata, FETCH_WORD);
        end
    endtask

    task automatic test_contention;
        logic prev_i;
        i_addr = 32'h1000;
        d_addr = 32'h200;
        d_we = 4'h0;
        for (int c = 0; c < 6; c++) begin
            tick();
            i_req = (c % 2 == 0);
            d_req = (c % 2 != 0);
            #2;
            checks++;
            if (i_gnt !== i_req || d_gnt !== d_req || mem_en !== 1'b1) begin
                failures++;
                $display("FAIL cont_gnt cyc=%0d i=%b d=%b en=%b", c, i_gnt, d_gnt, mem_en);
            end
            if (c > 0) begin
                prev_i = ((c - 1) % 2 == 0);
                checks++;
                if (i_rvalid !== prev_i || d_rvalid !== !prev_i
                    || d_rdata !== (prev_i ? FETCH_WORD : DATA_WORD)) begin
                    failures++;
                    $display("FAIL cont_rsp cyc=%0d iv=%b dv=%b data=%h want iv=%b",
                             c, i_rvalid, d_rvalid, d_rdata, prev_i);
                end
            end
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        checks++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== DATA_WORD) begin
            failures++;
            $display("FAIL cont_last dv=%b iv=%b data=%h want 1 0 %h",
                     d_rvalid, i_rvalid, d_rdata, DATA_WORD);
        end
    endtask

    task automatic test_reset_mid_read;
        logic exp_i;
        tick();
        i_req = 1'b1;
        i_addr = 32'h1000;
        d_req = 1'b0;
        #2;
        checks++;
        if (i_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt i_gnt=%b want 1", i_gnt);
        end
        tick();
        rst = 1'b0;
        d_req = 1'b1;
        #2;
        checks++;
        if (i_rvalid !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst iv=%b ig=%b dg=%b en=%b want 0 0 0 0",
                     i_rvalid, i_gnt, d_gnt, mem_en);
        end
        tick();
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after iv=%b dv=%b want 0 0", i_rvalid, d_rvalid);
        end
        tick();
        i_req = 1'b1;
        d_req = 1'b1;
        d_addr = 32'h200;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #2;
            exp_i = (c == 4);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                failures++;
                $display("FAIL cnt_clear cyc=%0d i=%b d=%b want i=%b", c, i_gnt, d_gnt, exp_i);
            end
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ram[32'h200 >> 2]  = DATA_WORD;
        ram[32'h1000 >> 2] = FETCH_WORD;
        ram[32'h300 >> 2]  = 32'h1122_3344;
        rst = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_we = '0;
        d_wdata = '0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_starvation();
        test_contention();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
